// File: rtl/hart_meter.sv
// Heartbeat rate meter: synchronises raw sensor pulses, qualifies them with a refractory
// period and counts qualified beats per window. `define HART_AVG_EN to average successive windows.
module hart_meter #(
   parameter int unsigned WINDOW  = 150,
   parameter int unsigned REFRACT = 3,
   parameter int unsigned LOSS    = 30
) (
   input  logic       slow,
   input  logic       reset,
   input  logic       beat,
   output logic [5:0] hart,
   output logic       hart_valid,
   output logic       beat_seen,
   output logic       lost
);

   localparam logic [15:0] WinLast = 16'(WINDOW - 1);
   localparam logic [15:0] RefrLd  = 16'(REFRACT);
   localparam logic [15:0] LossMax = 16'(LOSS);

   typedef enum logic {StArmed, StRefr} state_e;

   state_e      state_q;
   logic        sync1_q, sync2_q, sync3_q;
   logic [15:0] refr_q;
   logic [15:0] win_q, win_d;
   logic [15:0] loss_q, loss_d;
   logic [5:0]  cnt_q, cnt_inc;
   logic [5:0]  hart_q, hart_d;
   logic        valid_q, seen_q, lost_q, lost_d;
   logic        edge_det, qual, win_end;

   assign edge_det = sync2_q & ~sync3_q;
   assign qual     = edge_det && (state_q == StArmed);
   assign win_end  = (win_q == WinLast);

   assign hart       = hart_q;
   assign hart_valid = valid_q;
   assign beat_seen  = seen_q;
   assign lost       = lost_q;

`ifdef HART_AVG_EN
   logic [5:0] prev_q, prev_d;
   logic [6:0] avg_sum;

   always_ff @(posedge slow or negedge reset) begin
      if (!reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end
`endif

   always_comb begin
      win_d = win_end ? 16'd0 : win_q + 16'd1;

      cnt_inc = cnt_q;
      if (qual && (cnt_q != 6'd63)) begin
         cnt_inc = cnt_q + 6'd1;
      end

      loss_d = loss_q;
      if (qual) begin
         loss_d = '0;
      end else if (loss_q != LossMax) begin
         loss_d = loss_q + 16'd1;
      end
      lost_d = (loss_d == LossMax);

`ifdef HART_AVG_EN
      // Rounded mean of this and the previous window; a lost window restarts the history.
      avg_sum = {1'b0, prev_q} + {1'b0, cnt_inc} + 7'd1;
      hart_d  = lost_d ? 6'd0 : 6'(avg_sum >> 1);
      prev_d  = prev_q;
      if (win_end) begin
         prev_d = lost_d ? 6'd0 : cnt_inc;
      end
`else
      hart_d = lost_d ? 6'd0 : cnt_inc;
`endif
   end

   always_ff @(posedge slow or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         state_q <= StArmed;
         refr_q  <= '0;
         win_q   <= '0;
         loss_q  <= '0;
         cnt_q   <= '0;
         hart_q  <= '0;
         valid_q <= 1'b0;
         seen_q  <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         sync1_q <= beat;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         win_q   <= win_d;
         loss_q  <= loss_d;
         lost_q  <= lost_d;
         seen_q  <= qual;
         valid_q <= win_end;
         // A beat in the window-end cycle is folded into hart_d, so the next window starts at 0.
         if (win_end) begin
            cnt_q  <= '0;
            hart_q <= hart_d;
         end else begin
            cnt_q <= cnt_inc;
         end
         unique case (state_q)
            StArmed: begin
               if (edge_det) begin
                  state_q <= StRefr;
                  refr_q  <= RefrLd;
               end
            end
            StRefr: begin
               if (refr_q <= 16'd1) begin
                  state_q <= StArmed;
                  refr_q  <= '0;
               end else begin
                  refr_q <= refr_q - 16'd1;
               end
            end
            default: begin
               state_q <= StArmed;
               refr_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hart_meter.sv
// Scoreboard bench for hart_meter: a nominal instance (REFRACT=3) and a REFRACT=1 instance
// for count saturation. Expected events are queued by the stimulus and popped by a monitor.
module tb_hart_meter;

   logic       slow = 1'b0;
   logic       reset = 1'b0;
   logic       beat_m = 1'b0;
   logic       beat_s = 1'b0;
   logic [5:0] hart_m, hart_s;
   logic       hv_m, hv_s, seen_m, seen_s, lost_m, lost_s;

   hart_meter u_dut (
      .slow      (slow),
      .reset     (reset),
      .beat      (beat_m),
      .hart      (hart_m),
      .hart_valid(hv_m),
      .beat_seen (seen_m),
      .lost      (lost_m)
   );

   hart_meter #(.REFRACT(1)) u_sat (
      .slow      (slow),
      .reset     (reset),
      .beat      (beat_s),
      .hart      (hart_s),
      .hart_valid(hv_s),
      .beat_seen (seen_s),
      .lost      (lost_s)
   );

   always #5 slow = ~slow;

   // tick = index of the last posedge since reset release (first posedge is tick 0).
   int tick = -1;
   always @(posedge slow) begin
      if (!reset) tick <= -1;
      else        tick <= tick + 1;
   end

   typedef struct {
      int t;
      int v;
   } exp_t;

   exp_t q_hm[$];
   exp_t q_hs[$];
   exp_t q_lost[$];
   int   q_seen[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   run_mon = 1'b0;
   int   hold_m = 0;
   int   hold_s = 0;
   exp_t e;
   int   et;

`ifdef HART_AVG_EN
   localparam bit Avg = 1'b1;
`else
   localparam bit Avg = 1'b0;
`endif

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick);
      end
   endtask

   task automatic unexpected(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event with nothing expected (tick %0d)", name, tick);
   endtask

   task automatic push_hart(input int w, input int vm, input int vs);
      q_hm.push_back('{t: 149 + 150 * w, v: vm});
      q_hs.push_back('{t: 149 + 150 * w, v: vs});
   endtask

   task automatic push_lost(input int t, input int v);
      q_lost.push_back('{t: t, v: v});
   endtask

   task automatic pulses(input bit sat, input int start, input int step, input int n);
      for (int i = 0; i < n; i++) begin
         while (tick < start + step * i) @(negedge slow);
         if (sat) beat_s = 1'b1;
         else     beat_m = 1'b1;
         @(negedge slow);
         if (sat) beat_s = 1'b0;
         else     beat_m = 1'b0;
      end
   endtask

   always @(negedge slow) begin
      if (run_mon) begin
         if (hv_m) begin
            if (q_hm.size() == 0) begin
               unexpected("hart_valid main");
            end else begin
               e = q_hm.pop_front();
               check("hart_valid main tick", tick, e.t);
               check("hart main value", int'(hart_m), e.v);
               hold_m = e.v;
            end
         end else begin
            check("hart main held", int'(hart_m), hold_m);
         end
         if (hv_s) begin
            if (q_hs.size() == 0) begin
               unexpected("hart_valid sat");
            end else begin
               e = q_hs.pop_front();
               check("hart_valid sat tick", tick, e.t);
               check("hart sat value", int'(hart_s), e.v);
               hold_s = e.v;
            end
         end else begin
            check("hart sat held", int'(hart_s), hold_s);
         end
         if (seen_m) begin
            if (q_seen.size() == 0) begin
               unexpected("beat_seen main");
            end else begin
               et = q_seen.pop_front();
               check("beat_seen tick", tick, et);
            end
         end
         if (q_lost.size() != 0 && q_lost[0].t == tick) begin
            e = q_lost.pop_front();
            check("lost", int'(lost_m), e.v);
         end
      end
   end

   initial begin
      // Reset held with the sensor toggling.
      for (int i = 0; i < 6; i++) begin
         @(negedge slow);
         beat_m = ~beat_m;
         beat_s = ~beat_s;
      end
      check("reset hart", int'(hart_m), 0);
      check("reset hart_valid", int'(hv_m), 0);
      check("reset beat_seen", int'(seen_m), 0);
      check("reset lost", int'(lost_m), 0);
      check("reset sat hart", int'(hart_s), 0);
      beat_m = 1'b0;
      beat_s = 1'b0;

      // Window 0: no beats, lost after 30 ticks.
      push_hart(0, 0, 0);
      push_lost(28, 0);
      push_lost(29, 1);
      push_lost(154, 1);
      push_lost(155, 0);
      @(negedge slow);
      reset   = 1'b1;
      run_mon = 1'b1;

      // Window 1: 10 beats 15 apart; saturation instance gets 75 edges every 2 ticks.
      push_hart(1, Avg ? 5 : 10, Avg ? 32 : 63);
      for (int i = 0; i < 10; i++) q_seen.push_back(155 + 15 * i);
      fork
         pulses(1'b0, 152, 15, 10);
         pulses(1'b1, 148, 2, 75);
      join

      // Window 2: identical nominal window.
      push_hart(2, 10, 0);
      for (int i = 0; i < 10; i++) q_seen.push_back(305 + 15 * i);
      pulses(1'b0, 302, 15, 10);

      // Window 3: 20 edges every 2 ticks, every second one blocked by refractory.
      push_hart(3, 10, 0);
      push_lost(469, 0);
      push_lost(470, 1);
      push_lost(542, 1);
      push_lost(543, 0);
      for (int i = 0; i < 10; i++) q_seen.push_back(543 + 4 * i);
      pulses(1'b0, 540, 2, 20);

      // Window 4: 4 beats plus one qualified in the window-end cycle.
      push_hart(4, Avg ? 8 : 5, 0);
      q_seen.push_back(703);
      q_seen.push_back(713);
      q_seen.push_back(723);
      q_seen.push_back(733);
      q_seen.push_back(749);
      pulses(1'b0, 700, 10, 4);
      pulses(1'b0, 746, 1, 1);

      // Window 5: fresh count of 3.
      push_hart(5, Avg ? 4 : 3, 0);
      q_seen.push_back(843);
      q_seen.push_back(863);
      q_seen.push_back(883);
      pulses(1'b0, 840, 20, 3);

      // Window 6: one beat then silence.
      push_hart(6, 0, 0);
      push_lost(942, 0);
      push_lost(943, 1);
      push_lost(1049, 1);
      q_seen.push_back(913);
      pulses(1'b0, 910, 1, 1);

      // Window 7: next beat clears lost in its beat_seen cycle.
      push_hart(7, 0, 0);
      push_lost(1062, 1);
      push_lost(1063, 0);
      q_seen.push_back(1063);
      pulses(1'b0, 1060, 1, 1);

      while (tick < 1205) @(negedge slow);
      check("pending hart main", q_hm.size(), 0);
      check("pending hart sat", q_hs.size(), 0);
      check("pending beat_seen", q_seen.size(), 0);
      check("pending lost", q_lost.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
